collision_scanner: RTL and testbench

Frame-rate sequencer that sits directly upstream of the AABB overlap comparator. On a start pulse (typically vblank) it walks every unordered object pair (i<j) in the object box table. It fetches both boxes through a 1-cycle-latency read port and drives them onto the comparator's box1/box2 inputs. It then samples the comparator's overlap result and accumulates a per-object hit mask and a pair-hit count for the game CPU.

---
 rtl/collision_scanner.sv | 177 +++++++++++++++++
 tb/tb_collision_scanner.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scanner.sv
// Frame-rate pair sequencer for the AABB overlap comparator: walks every pair i<j of the box table,
// presents the boxes to the comparator and accumulates a per-object hit mask and a pair-hit count.
module collision_scanner #(
    parameter int unsigned POSITION_REG_MAX = 11,
    parameter int unsigned NUM_OBJ          = 8,
    parameter int unsigned OBJ_IDX_W        = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NUM_OBJ-1:0]            obj_active,
    output logic                          busy,
    output logic                          done,
    output logic                          obj_rd_en,
    output logic [OBJ_IDX_W-1:0]          obj_rd_idx,
    input  logic [POSITION_REG_MAX:0]     obj_rd_x1,
    input  logic [POSITION_REG_MAX:0]     obj_rd_y1,
    input  logic [POSITION_REG_MAX:0]     obj_rd_x2,
    input  logic [POSITION_REG_MAX:0]     obj_rd_y2,
    output logic [POSITION_REG_MAX:0]     box1_x1,
    output logic [POSITION_REG_MAX:0]     box1_y1,
    output logic [POSITION_REG_MAX:0]     box1_x2,
    output logic [POSITION_REG_MAX:0]     box1_y2,
    output logic [POSITION_REG_MAX:0]     box2_x1,
    output logic [POSITION_REG_MAX:0]     box2_y1,
    output logic [POSITION_REG_MAX:0]     box2_x2,
    output logic [POSITION_REG_MAX:0]     box2_y2,
    input  logic                          overlap,
    output logic [NUM_OBJ-1:0]            hit_mask,
    output logic [7:0]                    hit_count
);

    localparam int unsigned POS_W = POSITION_REG_MAX + 1;
    localparam logic [OBJ_IDX_W-1:0] LAST_J = OBJ_IDX_W'(NUM_OBJ - 1);
    localparam logic [OBJ_IDX_W-1:0] LAST_I = OBJ_IDX_W'(NUM_OBJ - 2);

    typedef struct packed {
        logic [POS_W-1:0] x1;
        logic [POS_W-1:0] y1;
        logic [POS_W-1:0] x2;
        logic [POS_W-1:0] y2;
    } box_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        CAP_A = 3'd2,
        RD_B  = 3'd3,
        CAP_B = 3'd4,
        CMP   = 3'd5,
        FIN   = 3'd6
    } state_t;

    state_t                 state_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   rd_en_q;
    logic [OBJ_IDX_W-1:0]   rd_idx_q;
    box_t                   box1_q;
    box_t                   box2_q;
    logic [NUM_OBJ-1:0]     act_q;
    logic [NUM_OBJ-1:0]     hit_mask_q;
    logic [7:0]             hit_count_q;
    logic [OBJ_IDX_W-1:0]   i_q;
    logic [OBJ_IDX_W-1:0]   j_q;

    box_t                   rd_box_c;
    logic                   pair_hit_c;

    assign rd_box_c   = {obj_rd_x1, obj_rd_y1, obj_rd_x2, obj_rd_y2};
    // Inactive objects are still compared so scan latency stays fixed; only their result is dropped.
    assign pair_hit_c = overlap & act_q[i_q] & act_q[j_q];

    // Sequencer: every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_idx_q    <= '0;
            box1_q      <= '0;
            box2_q      <= '0;
            act_q       <= '0;
            hit_mask_q  <= '0;
            hit_count_q <= '0;
            i_q         <= '0;
            j_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        act_q       <= obj_active;
                        hit_mask_q  <= '0;
                        hit_count_q <= '0;
                        i_q         <= '0;
                        j_q         <= OBJ_IDX_W'(1);
                        busy_q      <= 1'b1;
                        rd_en_q     <= 1'b1;
                        rd_idx_q    <= '0;
                        state_q     <= RD_A;
                    end
                end
                RD_A: begin
                    rd_en_q  <= 1'b1;
                    rd_idx_q <= j_q;
                    state_q  <= CAP_A;
                end
                // The j read issued here lands in CAP_B, so the first pair of a row skips RD_B.
                CAP_A: begin
                    box1_q  <= rd_box_c;
                    rd_en_q <= 1'b0;
                    state_q <= CAP_B;
                end
                RD_B: begin
                    rd_en_q <= 1'b0;
                    state_q <= CAP_B;
                end
                CAP_B: begin
                    box2_q  <= rd_box_c;
                    state_q <= CMP;
                end
                CMP: begin
                    if (pair_hit_c) begin
                        hit_mask_q[i_q] <= 1'b1;
                        hit_mask_q[j_q] <= 1'b1;
                        if (hit_count_q != 8'hFF) begin
                            hit_count_q <= hit_count_q + 8'd1;
                        end
                    end
                    if (j_q < LAST_J) begin
                        j_q      <= j_q + OBJ_IDX_W'(1);
                        rd_en_q  <= 1'b1;
                        rd_idx_q <= j_q + OBJ_IDX_W'(1);
                        state_q  <= RD_B;
                    end else if (i_q < LAST_I) begin
                        i_q      <= i_q + OBJ_IDX_W'(1);
                        j_q      <= i_q + OBJ_IDX_W'(2);
                        rd_en_q  <= 1'b1;
                        rd_idx_q <= i_q + OBJ_IDX_W'(1);
                        state_q  <= RD_A;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    rd_en_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign obj_rd_en  = rd_en_q;
    assign obj_rd_idx = rd_idx_q;
    assign box1_x1    = box1_q.x1;
    assign box1_y1    = box1_q.y1;
    assign box1_x2    = box1_q.x2;
    assign box1_y2    = box1_q.y2;
    assign box2_x1    = box2_q.x1;
    assign box2_y1    = box2_q.y1;
    assign box2_x2    = box2_q.x2;
    assign box2_y2    = box2_q.y2;
    assign hit_mask   = hit_mask_q;
    assign hit_count  = hit_count_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Scoreboard bench for collision_scanner: a box-table memory and strict-inequality comparator around
// the DUT, expected results from a pairwise reference model, checked by an independent monitor.
module tb_collision_scanner;

    localparam int unsigned PRM  = 11;
    localparam int unsigned N    = 8;
    localparam int unsigned IW   = 3;
    localparam int          P    = N * (N - 1) / 2;
    localparam int          SCAN = 3 * P + N - 1;

    typedef struct {
        logic [N-1:0] mask;
        int           cnt;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   obj_active;
    logic           busy, done, obj_rd_en, overlap;
    logic [IW-1:0]  obj_rd_idx;
    logic [PRM:0]   rd_x1, rd_y1, rd_x2, rd_y2;
    logic [PRM:0]   b1x1, b1y1, b1x2, b1y2, b2x1, b2y1, b2x2, b2y2;
    logic [N-1:0]   hit_mask;
    logic [7:0]     hit_count;

    logic [PRM:0]   tx1 [N];
    logic [PRM:0]   ty1 [N];
    logic [PRM:0]   tx2 [N];
    logic [PRM:0]   ty2 [N];

    exp_t exp_q [$];
    int   rd_q  [$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   done_cnt = 0;
    int   done_exp = 0;

    collision_scanner #(.POSITION_REG_MAX(PRM), .NUM_OBJ(N), .OBJ_IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .obj_active(obj_active),
        .busy(busy), .done(done), .obj_rd_en(obj_rd_en), .obj_rd_idx(obj_rd_idx),
        .obj_rd_x1(rd_x1), .obj_rd_y1(rd_y1), .obj_rd_x2(rd_x2), .obj_rd_y2(rd_y2),
        .box1_x1(b1x1), .box1_y1(b1y1), .box1_x2(b1x2), .box1_y2(b1y2),
        .box2_x1(b2x1), .box2_y1(b2y1), .box2_x2(b2x2), .box2_y2(b2y2),
        .overlap(overlap), .hit_mask(hit_mask), .hit_count(hit_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Box table with one-cycle read latency.
    always @(posedge clk) begin
        if (obj_rd_en) begin
            rd_x1 <= tx1[obj_rd_idx];
            rd_y1 <= ty1[obj_rd_idx];
            rd_x2 <= tx2[obj_rd_idx];
            rd_y2 <= ty2[obj_rd_idx];
        end
    end

    // External comparator: strict inequalities, so touching edges do not overlap.
    assign overlap = (b1x1 < b2x2) && (b2x1 < b1x2) && (b1y1 < b2y2) && (b2y1 < b1y2);

    task automatic check(input string name, input longint actv, input longint expv);
        total++;
        if (actv != expv) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, actv, expv, $time);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] act);
        exp_t r;
        r.mask = '0;
        r.cnt  = 0;
        for (int a = 0; a < N; a++) begin
            for (int b = a + 1; b < N; b++) begin
                if (act[a] && act[b] && tx1[a] < tx2[b] && tx1[b] < tx2[a]
                    && ty1[a] < ty2[b] && ty1[b] < ty2[a]) begin
                    r.mask[a] = 1'b1;
                    r.mask[b] = 1'b1;
                    r.cnt = (r.cnt < 255) ? r.cnt + 1 : 255;
                end
            end
        end
        return r;
    endfunction

    task automatic set_box(input int k, input int x1, input int y1, input int x2, input int y2);
        tx1[k] = PRM'(x1); ty1[k] = PRM'(y1);
        tx2[k] = PRM'(x2); ty2[k] = PRM'(y2);
    endtask

    task automatic random_table();
        for (int k = 0; k < N; k++) begin
            int x, y;
            x = int'($urandom_range(0, 60));
            y = int'($urandom_range(0, 60));
            set_box(k, x, y, x + int'($urandom_range(1, 24)), y + int'($urandom_range(1, 24)));
        end
    endtask

    // Monitor: consumes read and result expectations as the DUT presents them.
    int   mon_start_cyc;
    int   mon_busy_cnt;
    bit   mon_busy_prev;
    bit   mon_done_prev;
    int   mon_rd;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_busy_prev = 1'b0;
            mon_done_prev = 1'b0;
            mon_busy_cnt  = 0;
        end else begin
            if (obj_rd_en) begin
                if (rd_q.size() == 0) begin
                    check("rd_extra", 1, 0);
                end else begin
                    mon_rd = rd_q.pop_front();
                    check("rd_idx", longint'(obj_rd_idx), longint'(mon_rd));
                end
            end
            if (busy && !mon_busy_prev) begin
                mon_start_cyc = cyc;
                mon_busy_cnt  = 0;
            end
            if (busy) mon_busy_cnt++;
            if (!busy && mon_busy_prev) check("busy_len", mon_busy_cnt, SCAN + 1);
            if (done) begin
                done_cnt++;
                check("done_width", longint'(mon_done_prev), 0);
                check("busy_in_fin", longint'(busy), 1);
                check("done_latency", cyc - mon_start_cyc, SCAN);
                check("rd_remaining", rd_q.size(), 0);
                if (exp_q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("hit_mask", longint'(hit_mask), longint'(mon_e.mask));
                    check("hit_count", longint'(hit_count), longint'(mon_e.cnt));
                end
            end
            mon_busy_prev = busy;
            mon_done_prev = done;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_rd_en"}, longint'(obj_rd_en), 0);
        check({tag, "_rd_idx"}, longint'(obj_rd_idx), 0);
        check({tag, "_boxes"}, longint'(|{b1x1, b1y1, b1x2, b1y2, b2x1, b2y1, b2x2, b2y2}), 0);
        check({tag, "_hit_mask"}, longint'(hit_mask), 0);
        check({tag, "_hit_count"}, longint'(hit_count), 0);
    endtask

    // One scan: optional re-start pokes while busy/in FIN, optional reset abort at a scan cycle.
    task automatic run_scan(input logic [N-1:0] act, input int poke_at, input bit poke_fin,
                            input int abort_at);
        exp_t e;
        bit   got;
        int   dn;
        e = model(act);
        exp_q.push_back(e);
        for (int a = 0; a < N - 1; a++) begin
            for (int b = a; b < N; b++) rd_q.push_back(b);
        end
        @(posedge clk); #1;
        start = 1'b1;
        obj_active = act;
        @(posedge clk); #1;
        start = 1'b0;
        obj_active = N'($urandom);
        got = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (c == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                exp_q.delete();
                rd_q.delete();
                dn = done_cnt;
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
                repeat (100) @(posedge clk);
                #1;
                check("abort_no_done", done_cnt - dn, 0);
                check("abort_idle", longint'(busy), 0);
                return;
            end
            if (done) begin
                got = 1'b1;
                break;
            end
            start = (c == poke_at);
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (!got) begin
            check("done_timeout", 0, 1);
            return;
        end
        done_exp++;
        if (poke_fin) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int c = 0; c < 5 && busy; c++) begin
            @(posedge clk); #1;
        end
        for (int c = 0; c < 3; c++) begin
            check("idle_after", longint'(busy), 0);
            @(posedge clk); #1;
        end
        check("hold_mask", longint'(hit_mask), longint'(e.mask));
        check("hold_count", longint'(hit_count), longint'(e.cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        obj_active = '0;
        for (int k = 0; k < N; k++) set_box(k, 0, 0, 0, 0);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Reference layout: 0/1 overlap, 0/3 only touch at x=10, 2 and 4..7 isolated.
        set_box(0, 0, 0, 10, 10);
        set_box(1, 5, 5, 15, 15);
        set_box(2, 100, 100, 110, 110);
        set_box(3, 10, 0, 20, 10);
        for (int k = 4; k < N; k++) set_box(k, 200 + 30 * k, 300, 210 + 30 * k, 310);
        run_scan(8'hFF, -1, 1'b0, -1);
        run_scan(8'hFE, -1, 1'b0, -1);

        for (int k = 0; k < N; k++) set_box(k, 0, 0, 8, 8);
        run_scan(8'hFF, 10, 1'b1, -1);

        for (int t = 0; t < 6; t++) begin
            random_table();
            run_scan(N'($urandom), int'($urandom_range(2, 80)), t[0], -1);
        end

        random_table();
        run_scan(8'hFF, -1, 1'b0, 30);
        random_table();
        run_scan(8'hFF, -1, 1'b0, -1);

        repeat (3) @(posedge clk);
        #1;
        check("done_total", done_cnt, done_exp);
        check("exp_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
